// File: rtl/imm_decode_queue_pkg.sv
// -----------------------------------------------------------------------------
// imm_decode_queue_pkg
//   Shared RISC-V decode types for the decode-stage front end: opcode
//   constants, immediate format enum, queue occupancy state and the queue
//   entry payload.
//   No ports (package).
// -----------------------------------------------------------------------------
package imm_decode_queue_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned QUEUE_DEPTH = 2;
    localparam int unsigned OPC_W       = 7;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_ISH  = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_J    = 3'd5,
        FMT_U    = 3'd6
    } imm_fmt_e;

    // Occupancy count doubles as the FSM state.
    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        imm_fmt_e          fmt;
        logic              illegal;
    } q_entry_t;

    // Sign-extend a 12-bit I/S immediate to the datapath width.
    function automatic logic [DATA_W-1:0] sext12(input logic [11:0] v);
        return {{(DATA_W-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/imm_decode_queue_if.sv
// -----------------------------------------------------------------------------
// imm_decode_queue_if
//   Fetch-side and ID/EX-side handshakes of the decode queue.
//   master : fetch + downstream side (drives in_*, out_ready)
//   slave  : the decode queue (drives in_ready, out_*)
//   Signals: in_valid/in_ready/in_inst/in_pc,
//            out_valid/out_ready/out_inst/out_pc/out_imm/out_fmt/
//            out_target/out_illegal
// -----------------------------------------------------------------------------
interface imm_decode_queue_if;
    import imm_decode_queue_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_inst;
    logic [DATA_W-1:0] in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_inst;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_imm;
    imm_fmt_e          out_fmt;
    logic [DATA_W-1:0] out_target;
    logic              out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_imm, out_fmt,
               out_target, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_imm, out_fmt,
               out_target, out_illegal
    );
endinterface

// File: rtl/imm_decode_queue_imm_expand.sv
// -----------------------------------------------------------------------------
// imm_decode_queue_imm_expand
//   Combinational RV32I immediate expansion and format classification.
//   Optional macro: IMM_ILLEGAL_CHECK_EN enables the illegal-encoding flag;
//   without it illegal_c is tied 0.
//   Ports:
//     inst      in   32  instruction word
//     imm_c     out  32  expanded immediate
//     fmt_c     out  3   immediate format
//     illegal_c out  1   illegal encoding flag
// -----------------------------------------------------------------------------
module imm_decode_queue_imm_expand
    import imm_decode_queue_pkg::*;
(
    input  logic [DATA_W-1:0] inst,
    output logic [DATA_W-1:0] imm_c,
    output imm_fmt_e          fmt_c,
    output logic              illegal_c
);

    logic [OPC_W-1:0] opc;
    logic [2:0]       funct3;

    assign opc    = inst[6:0];
    assign funct3 = inst[14:12];

    // Immediate and format by opcode.
    always_comb begin
        imm_c = '0;
        fmt_c = FMT_NONE;
        case (opc)
            OPC_LOAD, OPC_JALR: begin
                imm_c = sext12(inst[31:20]);
                fmt_c = FMT_I;
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b101) begin
                    imm_c = {(DATA_W-5)'(0), inst[24:20]};
                    fmt_c = FMT_ISH;
                end else begin
                    imm_c = sext12(inst[31:20]);
                    fmt_c = FMT_I;
                end
            end
            OPC_STORE: begin
                imm_c = sext12({inst[31:25], inst[11:7]});
                fmt_c = FMT_S;
            end
            OPC_BRANCH: begin
                imm_c = {{(DATA_W-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                fmt_c = FMT_B;
            end
            OPC_JAL: begin
                imm_c = {{(DATA_W-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                fmt_c = FMT_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_c = {inst[31:12], 12'b0};
                fmt_c = FMT_U;
            end
            default: begin
                imm_c = '0;
                fmt_c = FMT_NONE;
            end
        endcase
    end

`ifdef IMM_ILLEGAL_CHECK_EN
    // Unknown opcode, non-32-bit encoding, or bad funct7 on OP-IMM shifts.
    always_comb begin
        illegal_c = (fmt_c == FMT_NONE) || (inst[1:0] != 2'b11);
        if (opc == OPC_OP_IMM) begin
            if ((funct3 == 3'b001) && (inst[31:25] != 7'b0000000)) begin
                illegal_c = 1'b1;
            end
            if ((funct3 == 3'b101) &&
                (inst[31:25] != 7'b0000000) && (inst[31:25] != 7'b0100000)) begin
                illegal_c = 1'b1;
            end
        end
    end
`else
    assign illegal_c = 1'b0;
`endif

endmodule

// File: rtl/imm_decode_queue.sv
// -----------------------------------------------------------------------------
// imm_decode_queue
//   Registered decode-stage front end: 2-entry skid queue between fetch and
//   ID/EX. Immediates are expanded at push and stored, so every output is a
//   flop. flush empties the queue and drops any same-cycle push.
//   Optional macro: IMM_ILLEGAL_CHECK_EN (out_illegal flag; tied 0 otherwise).
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  asynchronous active-high reset
//     flush  in  discard all queued entries
//     bus    slave modport of imm_decode_queue_if (in_* / out_* handshakes)
// -----------------------------------------------------------------------------
module imm_decode_queue
    import imm_decode_queue_pkg::*;
#(
    parameter int unsigned XLEN  = DATA_W,
    parameter int unsigned DEPTH = QUEUE_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    imm_decode_queue_if.slave  bus
);

    if ((XLEN != 32) || (DEPTH != 2)) begin : g_param_check
        $error("imm_decode_queue supports only XLEN=32 and DEPTH=2");
    end

    q_state_e          state_q;
    q_state_e          state_nxt;
    q_entry_t          head_q;
    q_entry_t          tail_q;
    q_entry_t          head_nxt;
    q_entry_t          tail_nxt;
    q_entry_t          new_entry;
    logic [DATA_W-1:0] target_q;
    logic [DATA_W-1:0] target_nxt;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              in_ready_nxt;
    logic              out_valid_nxt;
    logic              push_c;
    logic              pop_c;

    logic [DATA_W-1:0] exp_imm;
    imm_fmt_e          exp_fmt;
    logic              exp_illegal;

    imm_decode_queue_imm_expand u_imm_expand (
        .inst      (bus.in_inst),
        .imm_c     (exp_imm),
        .fmt_c     (exp_fmt),
        .illegal_c (exp_illegal)
    );

    // Entry built from the fetch side, decoded before it is stored.
    always_comb begin
        new_entry.inst    = bus.in_inst;
        new_entry.pc      = bus.in_pc;
        new_entry.imm     = exp_imm;
        new_entry.fmt     = exp_fmt;
        new_entry.illegal = exp_illegal;
    end

    assign push_c = bus.in_valid & in_ready_q;
    assign pop_c  = out_valid_q & bus.out_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= Q_EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state: occupancy update, flush dominates.
    always_comb begin
        state_nxt = state_q;
        if (flush) begin
            state_nxt = Q_EMPTY;
        end else begin
            case (state_q)
                Q_EMPTY: if (push_c) state_nxt = Q_ONE;
                Q_ONE: begin
                    if (push_c && !pop_c) begin
                        state_nxt = Q_FULL;
                    end else if (pop_c && !push_c) begin
                        state_nxt = Q_EMPTY;
                    end
                end
                Q_FULL:  if (pop_c) state_nxt = Q_ONE;
                default: state_nxt = Q_EMPTY;
            endcase
        end
    end

    // Output/datapath next values: slot moves and registered flags.
    always_comb begin
        head_nxt = head_q;
        tail_nxt = tail_q;
        if (!flush) begin
            case (state_q)
                Q_EMPTY: if (push_c) head_nxt = new_entry;
                Q_ONE: begin
                    if (push_c && pop_c) begin
                        head_nxt = new_entry;
                    end else if (push_c) begin
                        tail_nxt = new_entry;
                    end
                end
                Q_FULL:  if (pop_c) head_nxt = tail_q;
                default: head_nxt = head_q;
            endcase
        end
        // Target follows whatever lands in the head slot (32-bit wrap).
        target_nxt    = head_nxt.pc + head_nxt.imm;
        in_ready_nxt  = (state_nxt != Q_FULL);
        out_valid_nxt = (state_nxt != Q_EMPTY);
    end

    // Data and handshake flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            target_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            head_q      <= head_nxt;
            tail_q      <= tail_nxt;
            target_q    <= target_nxt;
            in_ready_q  <= in_ready_nxt;
            out_valid_q <= out_valid_nxt;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_inst    = head_q.inst;
    assign bus.out_pc      = head_q.pc;
    assign bus.out_imm     = head_q.imm;
    assign bus.out_fmt     = head_q.fmt;
    assign bus.out_target  = target_q;
    assign bus.out_illegal = head_q.illegal;

endmodule

// File: tb/tb_imm_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_imm_decode_queue
//   Self-checking bench for imm_decode_queue: vector table streamed through a
//   scoreboard, plus directed stall / flush / reset sequences.
// -----------------------------------------------------------------------------
module tb_imm_decode_queue;
    import imm_decode_queue_pkg::*;

`ifdef IMM_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    localparam int unsigned NVEC = 16;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        imm_fmt_e    fmt;
        logic [31:0] tgt;
        bit          chk_tgt;
        bit          ill;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    imm_decode_queue_if bus ();

    imm_decode_queue dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    vec_t        tab [NVEC];
    vec_t        sb [$];
    vec_t        cur;
    int          n_chk = 0;
    int          n_err = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_inst;
    logic [31:0] prev_imm;
    bit          acc;

    function automatic vec_t mk(logic [31:0] inst, logic [31:0] pc, logic [31:0] imm,
                                imm_fmt_e fmt, bit chk_tgt, bit ill);
        vec_t v;
        v.inst    = inst;
        v.pc      = pc;
        v.imm     = imm;
        v.fmt     = fmt;
        v.tgt     = pc + imm;
        v.chk_tgt = chk_tgt;
        v.ill     = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: monitor at negedge, then return #1 after the next posedge.
    task automatic tick(output bit accepted);
        accepted = 1'b0;
        @(negedge clk);
        if (prev_stall && bus.out_valid) begin
            chk("hold_inst", bus.out_inst, prev_inst);
            chk("hold_imm", bus.out_imm, prev_imm);
        end
        if (flush) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_out: got inst %h expected none", bus.out_inst);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    chk("out_inst", bus.out_inst, e.inst);
                    chk("out_pc", bus.out_pc, e.pc);
                    chk("out_imm", bus.out_imm, e.imm);
                    chk("out_fmt", 32'(bus.out_fmt), 32'(e.fmt));
                    chk("out_illegal", 32'(bus.out_illegal), 32'(ILL_EN & e.ill));
                    if (e.chk_tgt) chk("out_target", bus.out_target, e.tgt);
                end
            end
            accepted = bus.in_valid && bus.in_ready;
            if (accepted) sb.push_back(cur);
        end
        prev_stall = bus.out_valid && !bus.out_ready && !flush;
        prev_inst  = bus.out_inst;
        prev_imm   = bus.out_imm;
        @(posedge clk);
        #1;
    endtask

    // Present a vector until accepted; optionally randomize out_ready each cycle.
    task automatic push_vec(input vec_t v, input bit rnd);
        bit done;
        done         = 1'b0;
        cur          = v;
        bus.in_valid = 1'b1;
        bus.in_inst  = v.inst;
        bus.in_pc    = v.pc;
        for (int i = 0; i < 32 && !done; i++) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            tick(done);
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL push_timeout: got not accepted expected accepted inst %h", v.inst);
        end
    endtask

    task automatic drain();
        bit a;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(a);
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        tab[0]  = mk(32'hFFF00093, 32'h0000_0000, 32'hFFFFFFFF, FMT_I,    1'b0, 1'b0);
        tab[1]  = mk(32'h4030D093, 32'h0000_0004, 32'h00000003, FMT_ISH,  1'b0, 1'b0);
        tab[2]  = mk(32'hFE000EE3, 32'h0000_0100, 32'hFFFFFFFC, FMT_B,    1'b1, 1'b0);
        tab[3]  = mk(32'h123450B7, 32'h0000_0008, 32'h12345000, FMT_U,    1'b0, 1'b0);
        tab[4]  = mk(32'h0080006F, 32'h0000_0200, 32'h00000008, FMT_J,    1'b1, 1'b0);
        tab[5]  = mk(32'hFFC12083, 32'h0000_0010, 32'hFFFFFFFC, FMT_I,    1'b0, 1'b0);
        tab[6]  = mk(32'h00008067, 32'h0000_0014, 32'h00000000, FMT_I,    1'b0, 1'b0);
        tab[7]  = mk(32'h00512623, 32'h0000_0018, 32'h0000000C, FMT_S,    1'b0, 1'b0);
        tab[8]  = mk(32'hFE112E23, 32'h0000_001C, 32'hFFFFFFFC, FMT_S,    1'b0, 1'b0);
        tab[9]  = mk(32'h00001117, 32'h0000_1000, 32'h00001000, FMT_U,    1'b1, 1'b0);
        tab[10] = mk(32'h00000033, 32'h0000_0020, 32'h00000000, FMT_NONE, 1'b0, 1'b1);
        tab[11] = mk(32'hFE000EE3, 32'h0000_0000, 32'hFFFFFFFC, FMT_B,    1'b1, 1'b0);
        tab[12] = mk(32'h00309093, 32'h0000_0024, 32'h00000003, FMT_I,    1'b0, 1'b0);
        tab[13] = mk(32'hFFDFF06F, 32'h0000_0300, 32'hFFFFFFFC, FMT_J,    1'b1, 1'b0);
        tab[14] = mk(32'h00000000, 32'h0000_0028, 32'h00000000, FMT_NONE, 1'b0, 1'b1);
        tab[15] = mk(32'h8030D093, 32'h0000_002C, 32'h00000003, FMT_ISH,  1'b0, 1'b1);

        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_imm", bus.out_imm, 32'd0);

        // Single push into empty queue is visible one cycle later.
        push_vec(tab[0], 1'b0);
        chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_out_imm", bus.out_imm, 32'hFFFFFFFF);
        chk("lat_out_fmt", 32'(bus.out_fmt), 32'(FMT_I));
        drain();

        // Stall until full, then release.
        bus.out_ready = 1'b0;
        push_vec(tab[3], 1'b0);
        push_vec(tab[4], 1'b0);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_head_imm", bus.out_imm, 32'h12345000);
        cur          = tab[10];
        bus.in_valid = 1'b1;
        bus.in_inst  = tab[10].inst;
        bus.in_pc    = tab[10].pc;
        tick(acc);
        bus.in_valid = 1'b0;
        chk("full_no_accept", 32'(acc), 32'd0);
        bus.out_ready = 1'b1;
        tick(acc);
        chk("next_head_imm", bus.out_imm, 32'h00000008);
        drain();

        // Back-to-back stream, then a pass with random back-pressure.
        bus.out_ready = 1'b1;
        for (int i = 0; i < int'(NVEC); i++) push_vec(tab[i], 1'b0);
        drain();
        for (int i = 0; i < int'(NVEC); i++) push_vec(tab[i], 1'b1);
        drain();
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

        // Flush while full with a concurrent push.
        bus.out_ready = 1'b0;
        push_vec(tab[5], 1'b0);
        push_vec(tab[7], 1'b0);
        flush         = 1'b1;
        cur           = tab[9];
        bus.in_valid  = 1'b1;
        bus.in_inst   = tab[9].inst;
        bus.in_pc     = tab[9].pc;
        tick(acc);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        repeat (3) tick(acc);
        chk("flush_no_ghost", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset while full.
        bus.out_ready = 1'b0;
        push_vec(tab[2], 1'b0);
        push_vec(tab[13], 1'b0);
        chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        sb.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_imm", bus.out_imm, 32'd0);
        reset = 1'b0;
        push_vec(tab[9], 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
